// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked arbiter sharing one uart_transmit among NUM_REQ byte streams
// Optional macro UART_ARB_TAG_EN: send header byte {4'hA, id} after every grant.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [NUM_REQ-1:0]   req_valid_in,
    input  logic [8*NUM_REQ-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]   req_last_in,
    output logic [NUM_REQ-1:0]   req_ready_out,
    output logic [NUM_REQ-1:0]   grant_out,
    input  logic                 tx_busy_in,
    output logic                 tx_trigger_out,
    output logic [7:0]           tx_data_out,
    output logic                 timeout_out
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam bit TO_EN = (IDLE_TIMEOUT > 0);
    localparam logic [CW-1:0] CNT_LAST = (IDLE_TIMEOUT > 0) ? CW'(IDLE_TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
`ifdef UART_ARB_TAG_EN
        S_TAG     = 3'd1,
`endif
        S_FETCH   = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT_HI = 3'd4,
        S_WAIT_LO = 3'd5
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IW-1:0]      last_grant_q;
    logic               last_q;
    logic [CW-1:0]      idle_cnt_q;
    logic               trigger_q;
    logic [7:0]         data_q;
    logic               timeout_q;

    logic [IW-1:0]      win_d;
    logic               any_d;
    logic [IW-1:0]      cand;
    logic [7:0]         sel_data;
    logic               sel_last;
    logic               accept;

    // Scan downwards so the candidate closest after last_grant is assigned last and wins.
    always_comb begin
        win_d = last_grant_q;
        any_d = 1'b0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(last_grant_q) + k) % NUM_REQ);
            if (req_valid_in[cand]) begin
                win_d = cand;
                any_d = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = 8'h00;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (last_grant_q == IW'(i)) begin
                sel_data = req_data_in[8*i +: 8];
                sel_last = req_last_in[i];
            end
        end
    end

    assign req_ready_out  = (state_q == S_FETCH) ? grant_q : '0;
    assign accept         = |(req_valid_in & req_ready_out);
    assign grant_out      = grant_q;
    assign tx_trigger_out = trigger_q;
    assign tx_data_out    = data_q;
    assign timeout_out    = timeout_q;

    // trigger_q is loaded on the edge into ISSUE so the pulse is visible during the ISSUE cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_REQ - 1);
            last_q       <= 1'b0;
            idle_cnt_q   <= '0;
            trigger_q    <= 1'b0;
            data_q       <= 8'h00;
            timeout_q    <= 1'b0;
        end else begin
            trigger_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_d) begin
                        grant_q      <= NUM_REQ'(1) << win_d;
                        last_grant_q <= win_d;
                        idle_cnt_q   <= '0;
`ifdef UART_ARB_TAG_EN
                        state_q      <= S_TAG;
`else
                        state_q      <= S_FETCH;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                S_TAG: begin
                    data_q    <= {4'hA, 4'(last_grant_q)};
                    last_q    <= 1'b0;
                    trigger_q <= ~tx_busy_in;
                    state_q   <= S_ISSUE;
                end
`endif
                S_FETCH: begin
                    if (accept) begin
                        data_q     <= sel_data;
                        last_q     <= sel_last;
                        idle_cnt_q <= '0;
                        trigger_q  <= ~tx_busy_in;
                        state_q    <= S_ISSUE;
                    end else if (TO_EN && idle_cnt_q == CNT_LAST) begin
                        grant_q    <= '0;
                        timeout_q  <= 1'b1;
                        idle_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end else if (idle_cnt_q != CNT_MAX) begin
                        idle_cnt_q <= idle_cnt_q + CW'(1);
                    end
                end
                S_ISSUE: begin
                    if (trigger_q) begin
                        state_q <= S_WAIT_HI;
                    end else if (!tx_busy_in) begin
                        trigger_q <= 1'b1;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_busy_in) begin
                        state_q <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy_in) begin
                        if (last_q) begin
                            grant_q <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized packet-level bench for uart_tx_arbiter with a behavioural transmitter
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int TO = 8;
    localparam int BOUND = 5000;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   grant;
    logic            tx_busy;
    logic            tx_trigger;
    logic [7:0]      tx_data;
    logic            timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .IDLE_TIMEOUT(TO)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .req_valid_in   (req_valid),
        .req_data_in    (req_data),
        .req_last_in    (req_last),
        .req_ready_out  (req_ready),
        .grant_out      (grant),
        .tx_busy_in     (tx_busy),
        .tx_trigger_out (tx_trigger),
        .tx_data_out    (tx_data),
        .timeout_out    (timeout)
    );

    // Transmitter stand-in: busy rises the cycle after a trigger and lasts a random frame length.
    int frame_left;
    always @(posedge clk) begin
        if (rst) begin
            tx_busy    <= 1'b0;
            frame_left <= 0;
        end else if (tx_trigger && !tx_busy) begin
            tx_busy    <= 1'b1;
            frame_left <= int'($urandom_range(2, 8));
        end else if (tx_busy) begin
            if (frame_left <= 1) tx_busy <= 1'b0;
            frame_left <= frame_left - 1;
        end
    end

    logic [8:0]  pq [NR][$];
    logic [8:0]  mq [NR][$];
    int          gap [NR];
    logic [NR-1:0] acc_pend;
    logic [NR-1:0] prev_grant;
    logic [7:0]  obs_bytes[$];
    logic [7:0]  exp_bytes[$];
    int          obs_grants[$];
    int          exp_grants[$];
    int          m_last;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int onehot_idx(input logic [NR-1:0] v);
        int r = -1;
        for (int i = NR - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NR; i++) n += pq[i].size();
        return n;
    endfunction

    task automatic tick();
        logic [8:0] e;
        @(negedge clk);
        if (tx_trigger) begin
            check("trig_while_busy", tx_busy, 0);
            obs_bytes.push_back(tx_data);
        end
        if (grant != 0 && prev_grant == 0) begin
            check("grant_onehot", $onehot(grant), 1);
            obs_grants.push_back(onehot_idx(grant));
        end
        if (req_ready != 0) check("ready_eq_grant", req_ready, grant);
        prev_grant = grant;
        for (int i = 0; i < NR; i++) begin
            if (acc_pend[i] && !rst) begin
                e = pq[i].pop_front();
                gap[i] = e[8] ? 0 : int'($urandom_range(0, 3));
            end else if (gap[i] > 0) begin
                gap[i]--;
            end
            if (pq[i].size() > 0 && gap[i] == 0) begin
                e = pq[i][0];
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = e[7:0];
                req_last[i]         = e[8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'($urandom);
                req_last[i]         = 1'($urandom);
            end
        end
        acc_pend = req_valid & req_ready;
    endtask

    task automatic add_packet(input int r, input int len);
        logic [8:0] e;
        for (int j = 0; j < len; j++) begin
            e = {(j == len - 1) ? 1'b1 : 1'b0, 8'($urandom)};
            pq[r].push_back(e);
            mq[r].push_back(e);
        end
    endtask

    // Packet-level reference: round-robin over requesters with queued packets, whole packet per grant.
    task automatic start_scenario();
        int r;
        logic [8:0] e;
        obs_bytes.delete();
        obs_grants.delete();
        exp_bytes.delete();
        exp_grants.delete();
        forever begin
            r = -1;
            for (int k = 1; k <= NR && r < 0; k++)
                if (mq[(m_last + k) % NR].size() > 0) r = (m_last + k) % NR;
            if (r < 0) break;
            exp_grants.push_back(r);
`ifdef UART_ARB_TAG_EN
            exp_bytes.push_back({4'hA, 4'(r)});
`endif
            do begin
                e = mq[r].pop_front();
                exp_bytes.push_back(e[7:0]);
            end while (!e[8]);
            m_last = r;
        end
    endtask

    task automatic finish_scenario(input string name);
        int cyc = 0;
        while ((pending() > 0 || grant != 0 || tx_busy) && cyc < BOUND) begin
            tick();
            cyc++;
        end
        check({name, "_bounded"}, cyc < BOUND, 1);
        check({name, "_nbytes"}, obs_bytes.size(), exp_bytes.size());
        check({name, "_ngrants"}, obs_grants.size(), exp_grants.size());
        for (int k = 0; k < obs_bytes.size() && k < exp_bytes.size(); k++)
            check($sformatf("%s_byte%0d", name, k), obs_bytes[k], exp_bytes[k]);
        for (int k = 0; k < obs_grants.size() && k < exp_grants.size(); k++)
            check($sformatf("%s_grant%0d", name, k), obs_grants[k], exp_grants[k]);
        check({name, "_idle"}, grant, 0);
        repeat (2) tick();
    endtask

    initial begin
        int cyc;
        int f0;
        n_checks   = 0;
        n_pass     = 0;
        m_last     = NR - 1;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        acc_pend   = '0;
        prev_grant = '0;
        for (int i = 0; i < NR; i++) gap[i] = 0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_ready", req_ready, 0);
        check("rst_grant", grant, 0);
        check("rst_trigger", tx_trigger, 0);
        check("rst_data", tx_data, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;
        tick();

        // Single byte from requester 0.
        pq[0].push_back({1'b1, 8'h55});
        mq[0].push_back({1'b1, 8'h55});
        start_scenario();
        tick();
        tick();
        check("single_grant", grant, 4'b0001);
`ifndef UART_ARB_TAG_EN
        check("single_ready", req_ready, 4'b0001);
        tick();
        check("single_trigger", tx_trigger, 1);
        check("single_data", tx_data, 8'h55);
`endif
        finish_scenario("single");

        // Contention between requesters 1 and 3 with 2-byte packets.
        add_packet(1, 2);
        add_packet(1, 2);
        add_packet(3, 2);
        start_scenario();
        finish_scenario("contend");

        // Fairness wrap: last owner 3, then 0 and 3 both request.
        add_packet(3, 1);
        start_scenario();
        finish_scenario("wrap_pre");
        add_packet(3, 2);
        add_packet(0, 1);
        start_scenario();
        finish_scenario("wrap");
        check("wrap_first_owner", (obs_grants.size() > 0) ? obs_grants[0] : -1, 0);

        // Timeout: requester 2 sends one non-last byte then goes quiet.
        pq[2].push_back({1'b0, 8'hC3});
        cyc = 0;
        while (pq[2].size() > 0 && cyc < BOUND) begin tick(); cyc++; end
        while (req_ready != 4'b0100 && cyc < BOUND) begin tick(); cyc++; end
        f0 = cyc;
        while (!timeout && cyc < BOUND) begin tick(); cyc++; end
        check("to_bounded", cyc < BOUND, 1);
        check("to_latency", cyc - f0, TO);
        check("to_grant_clear", grant, 0);
        tick();
        check("to_single_pulse", timeout, 0);
        m_last = 2;

        // Reset while the transmitter is mid-frame.
        pq[1].push_back({1'b1, 8'h77});
        cyc = 0;
        while (!tx_busy && cyc < BOUND) begin tick(); cyc++; end
        tick();
        check("rstmid_reached", cyc < BOUND, 1);
        rst = 1'b1;
        tick();
        check("rstmid_ready", req_ready, 0);
        check("rstmid_grant", grant, 0);
        check("rstmid_trigger", tx_trigger, 0);
        check("rstmid_data", tx_data, 0);
        check("rstmid_timeout", timeout, 0);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin pq[i].delete(); mq[i].delete(); gap[i] = 0; end
        m_last = NR - 1;
        add_packet(2, 2);
        add_packet(0, 2);
        start_scenario();
        finish_scenario("post_rst");
        check("post_rst_first_owner", (obs_grants.size() > 0) ? obs_grants[0] : -1, 0);

        // Randomized rounds.
        for (int rnd = 0; rnd < 8; rnd++) begin
            for (int r = 0; r < NR; r++)
                if ($urandom_range(0, 1) == 1)
                    repeat ($urandom_range(1, 3)) add_packet(r, int'($urandom_range(1, 4)));
            if (pending() == 0) add_packet(int'($urandom_range(0, NR - 1)), 1);
            start_scenario();
            finish_scenario($sformatf("rand%0d", rnd));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
